// File: rtl/pipe_id_rf_read_pkg.sv
// Shared constants and types for the decode-stage operand reader.
package pipe_id_rf_read_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int RA_W     = $clog2(NREG_DEF);

    localparam logic [RA_W-1:0] REG0 = '0;

    typedef enum logic [1:0] {
        SRC_RF,
        SRC_WB,
        SRC_MEM,
        SRC_EX
    } bypass_src_e;

endpackage

// File: rtl/pipe_id_rf_read_regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port.
// A same-cycle write is visible on the read ports; register 0 always reads 0.
module pipe_id_rf_read_regfile_2r1w
    import pipe_id_rf_read_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != AW'(REG0));

    // Storage is intentionally left unreset; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == AW'(REG0))                 ? '0      :
                      (wr_en && (waddr_i == raddr1_i))        ? wdata_i :
                                                                regs_q[raddr1_i];

    assign rdata2_o = (raddr2_i == AW'(REG0))                 ? '0      :
                      (wr_en && (waddr_i == raddr2_i))        ? wdata_i :
                                                                regs_q[raddr2_i];

endmodule

// File: rtl/pipe_id_rf_read.sv
// Decode stage: IF->ID pipeline register, two-source operand read with EX/MEM/WB
// bypass and load-use stall. Define BYPASS_EN to enable EX/MEM forwarding.
module pipe_id_rf_read
    import pipe_id_rf_read_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            from_valid,
    input  logic [XLEN-1:0] from_pc,
    input  logic [31:0]     from_inst,
    output logic            to_allowin,

    output logic            to_valid,
    input  logic            from_allowin,
    output logic [XLEN-1:0] PC,
    output logic [31:0]     inst,

    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    input  logic            r1_used,
    input  logic            r2_used,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,

    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_res_from_mem,
    input  logic [AW-1:0]   ex_waddr,
    input  logic [XLEN-1:0] ex_wdata,

    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [XLEN-1:0] mem_wdata,

    input  logic            wb_valid,
    input  logic            rf_we,
    input  logic [AW-1:0]   rf_waddr,
    input  logic [XLEN-1:0] rf_wdata
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;

    logic            ready_go, stall;
    logic            m1_ex, m1_mem, m1_wb;
    logic            m2_ex, m2_mem, m2_wb;
    bypass_src_e     src1, src2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;

    function automatic logic src_hit(input logic v, input logic w,
                                     input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                                     input logic used);
        return v & w & (wa == ra) & (ra != AW'(REG0)) & used;
    endfunction

    function automatic bypass_src_e pick_src(input logic hit_ex, input logic hit_mem,
                                             input logic hit_wb);
        if (hit_ex)  return SRC_EX;
        if (hit_mem) return SRC_MEM;
        if (hit_wb)  return SRC_WB;
        return SRC_RF;
    endfunction

    function automatic logic [XLEN-1:0] sel_operand(input bypass_src_e src,
                                                    input logic [XLEN-1:0] ex_v,
                                                    input logic [XLEN-1:0] mem_v,
                                                    input logic [XLEN-1:0] wb_v,
                                                    input logic [XLEN-1:0] rf_v);
        case (src)
            SRC_EX:  return ex_v;
            SRC_MEM: return mem_v;
            SRC_WB:  return wb_v;
            default: return rf_v;
        endcase
    endfunction

    pipe_id_rf_read_regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk      (clk),
        .we_i     (wb_valid & rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata),
        .raddr1_i (raddr1),
        .raddr2_i (raddr2),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    assign m1_ex  = src_hit(ex_valid,  ex_we,  ex_waddr,  raddr1, r1_used);
    assign m1_mem = src_hit(mem_valid, mem_we, mem_waddr, raddr1, r1_used);
    assign m1_wb  = src_hit(wb_valid,  rf_we,  rf_waddr,  raddr1, r1_used);
    assign m2_ex  = src_hit(ex_valid,  ex_we,  ex_waddr,  raddr2, r2_used);
    assign m2_mem = src_hit(mem_valid, mem_we, mem_waddr, raddr2, r2_used);
    assign m2_wb  = src_hit(wb_valid,  rf_we,  rf_waddr,  raddr2, r2_used);

`ifdef BYPASS_EN
    // Only a load in EX has no value yet; everything else forwards.
    assign stall = valid_q & ((m1_ex | m2_ex) & ex_res_from_mem);
    assign src1  = pick_src(m1_ex, m1_mem, m1_wb);
    assign src2  = pick_src(m2_ex, m2_mem, m2_wb);
`else
    // Without forwarding, wait until the producer reaches WB.
    assign stall = valid_q & (m1_ex | m2_ex | m1_mem | m2_mem);
    assign src1  = pick_src(1'b0, 1'b0, m1_wb);
    assign src2  = pick_src(1'b0, 1'b0, m2_wb);
    logic unused_load_flag;
    assign unused_load_flag = ex_res_from_mem;
`endif

    assign rdata1 = sel_operand(src1, ex_wdata, mem_wdata, rf_wdata, rf_rdata1);
    assign rdata2 = sel_operand(src2, ex_wdata, mem_wdata, rf_wdata, rf_rdata2);

    assign ready_go   = valid_q & ~stall;
    assign to_allowin = ~valid_q | (ready_go & from_allowin);
    assign to_valid   = valid_q & ready_go;
    assign PC         = pc_q;
    assign inst       = inst_q;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (to_allowin) begin
            valid_d = from_valid;
        end
        if (from_valid && to_allowin) begin
            pc_d   = from_pc;
            inst_d = from_inst;
        end
    end

    // IF -> ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

endmodule
